// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_ctrl_pkg
// Purpose : Shared encodings for the multicycle MIPS main controller and the
//           downstream ALU function controller: FSM states, opcodes, alu_op
//           codes, ALU operand-B and PC source selectors, fault codes, and
//           opcode classes.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        CLS_LS  = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_BR  = 3'd3,
        CLS_J   = 3'd4,
        CLS_ILL = 3'd5
    } op_class_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ANDI  = 6'b001100;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    // alu_op codes, shared with the ALU function controller
    localparam logic [2:0] C_ALU_NONE  = 3'b000;
    localparam logic [2:0] C_ALU_BEQ   = 3'b001;
    localparam logic [2:0] C_ALU_RTYPE = 3'b010;
    localparam logic [2:0] C_ALU_AND   = 3'b100;
    localparam logic [2:0] C_ALU_ADD   = 3'b101;
    localparam logic [2:0] C_ALU_OR    = 3'b110;
    localparam logic [2:0] C_ALU_BNE   = 3'b111;

    // ALU operand-B selector
    localparam logic [1:0] C_SRCB_REG   = 2'b00;
    localparam logic [1:0] C_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] C_SRCB_IMM   = 2'b10;
    localparam logic [1:0] C_SRCB_BROFF = 2'b11;

    // PC source selector
    localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

    // Fault codes
    localparam logic [1:0] C_FAULT_NONE    = 2'b00;
    localparam logic [1:0] C_FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] C_FAULT_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module  : mips_opcode_decoder
// Purpose : Combinational opcode classifier for the multicycle controller.
// Ports   : opcode      in  6  IR[31:26]
//           op_class    out 3  LS / R / I / BR / J / ILL
//           is_lw       out 1  load (vs store) within the LS class
//           is_bne      out 1  bne (vs beq) within the BR class
//           exec_alu_op out 3  alu_op for the I-type execute state
//           ext_zero    out 1  zero-extend immediate (andi/ori)
// Revision: 1.0 - initial release
// ============================================================================
module mips_opcode_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_e  op_class,
    output logic       is_lw,
    output logic       is_bne,
    output logic [2:0] exec_alu_op,
    output logic       ext_zero
);

    always_comb begin
        op_class    = CLS_ILL;
        is_lw       = 1'b0;
        is_bne      = 1'b0;
        exec_alu_op = C_ALU_ADD;
        ext_zero    = 1'b0;
        case (opcode)
            C_OP_LW:    begin op_class = CLS_LS; is_lw = 1'b1; end
            C_OP_SW:    op_class = CLS_LS;
            C_OP_RTYPE: op_class = CLS_R;
            C_OP_ADDI:  op_class = CLS_I;
            C_OP_ANDI:  begin op_class = CLS_I; exec_alu_op = C_ALU_AND; ext_zero = 1'b1; end
            C_OP_ORI:   begin op_class = CLS_I; exec_alu_op = C_ALU_OR;  ext_zero = 1'b1; end
            C_OP_BEQ:   op_class = CLS_BR;
            C_OP_BNE:   begin op_class = CLS_BR; is_bne = 1'b1; end
            C_OP_J:     op_class = CLS_J;
            default:    op_class = CLS_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_ctrl
// Purpose : Main control FSM of the multicycle MIPS datapath. Sequences
//           fetch/decode/execute/memory/writeback, handshakes with a
//           variable-latency memory and traps on illegal opcodes or memory
//           timeouts (fault is sticky until reset).
// Ports   : clk, rst_n (sync, active-low); opcode[5:0], zero, mem_ready in;
//           pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//           reg_write, ext_zero, alu_src_a, alu_src_b[1:0], pc_source[1:0],
//           alu_op[2:0], state[3:0], fault[1:0] out.
// Revision: 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       ext_zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic [1:0] fault
);

    // Trap fires on the TIMEOUT-th consecutive waiting cycle
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [1:0]      fault_q, fault_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    op_class_e  w_class;
    logic       w_is_lw, w_is_bne, w_ext_zero;
    logic [2:0] w_exec_alu_op;
    logic       w_timeout;
    state_e     w_next;
    logic       w_pc_write, w_br_take, w_mem_read, w_mem_write, w_ir_write, w_reg_write;

    mips_opcode_decoder u_dec (
        .opcode      (opcode),
        .op_class    (w_class),
        .is_lw       (w_is_lw),
        .is_bne      (w_is_bne),
        .exec_alu_op (w_exec_alu_op),
        .ext_zero    (w_ext_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fault_q    <= C_FAULT_NONE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state, fault capture and memory wait counter
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        w_timeout = (wait_cnt_q == C_TO_LAST) && !mem_ready;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (w_timeout) begin state_d = S_TRAP; fault_d = C_FAULT_TIMEOUT; end
            end
            S_DECODE: begin
                case (w_class)
                    CLS_LS:  state_d = S_MEM_ADDR;
                    CLS_R:   state_d = S_EXEC_R;
                    CLS_I:   state_d = S_EXEC_I;
                    CLS_BR:  state_d = S_BRANCH;
                    CLS_J:   state_d = S_JUMP;
                    default: begin state_d = S_TRAP; fault_d = C_FAULT_ILLEGAL; end
                endcase
            end
            S_MEM_ADDR:  state_d = w_is_lw ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready)      state_d = S_MEM_WB;
                else if (w_timeout) begin state_d = S_TRAP; fault_d = C_FAULT_TIMEOUT; end
            end
            S_MEM_WRITE: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (w_timeout) begin state_d = S_TRAP; fault_d = C_FAULT_TIMEOUT; end
            end
            S_EXEC_R:    state_d = S_R_WB;
            S_EXEC_I:    state_d = S_I_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;  // WB states, BRANCH, JUMP, unused codes
        endcase

        // Only the memory-wait states self-loop (besides TRAP), so "stayed put"
        // is exactly "waited without mem_ready"; any state change clears it.
        if ((state_d == state_q) && (state_q != S_TRAP)) wait_cnt_d = wait_cnt_q + TO_W'(1);
        else                                             wait_cnt_d = '0;
    end

    // alu_op looks one state ahead: the ALU controller registers it as the FSM
    // enters the state. During reset the next state is always FETCH.
    always_comb begin
        w_next = rst_n ? state_d : S_FETCH;
        case (w_next)
            S_FETCH, S_DECODE, S_MEM_ADDR: alu_op = C_ALU_ADD;
            S_EXEC_R:                      alu_op = C_ALU_RTYPE;
            S_EXEC_I:                      alu_op = w_exec_alu_op;
            S_BRANCH:                      alu_op = w_is_bne ? C_ALU_BNE : C_ALU_BEQ;
            default:                       alu_op = C_ALU_NONE;
        endcase
    end

    // Moore output decode
    always_comb begin
        w_pc_write  = 1'b0;
        w_br_take   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        ext_zero    = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = C_SRCB_REG;
        pc_source   = C_PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = C_SRCB_FOUR;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE:    alu_src_b = C_SRCB_BROFF;
            S_MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = C_SRCB_IMM; end
            S_MEM_READ:  begin w_mem_read = 1'b1; iord = 1'b1; end
            S_MEM_WRITE: begin w_mem_write = 1'b1; iord = 1'b1; end
            S_MEM_WB:    begin w_reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_EXEC_R:    alu_src_a = 1'b1;
            S_R_WB:      begin w_reg_write = 1'b1; reg_dst = 1'b1; end
            S_EXEC_I:    begin alu_src_a = 1'b1; alu_src_b = C_SRCB_IMM; ext_zero = w_ext_zero; end
            S_I_WB:      w_reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_source = C_PCSRC_ALUOUT;
                w_br_take = w_is_bne ? !zero : zero;
            end
            S_JUMP:      begin w_pc_write = 1'b1; pc_source = C_PCSRC_JUMP; end
            default:     ;
        endcase
    end

    // Side-effecting enables are suppressed while reset is held
    assign pc_en     = rst_n & (w_pc_write | w_br_take);
    assign mem_read  = rst_n & w_mem_read;
    assign mem_write = rst_n & w_mem_write;
    assign ir_write  = rst_n & w_ir_write;
    assign reg_write = rst_n & w_reg_write;
    assign state     = state_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_multicycle_ctrl
// Purpose : Self-checking bench for mips_multicycle_ctrl (TIMEOUT=4). Each
//           driven cycle pushes its expected output vector to a scoreboard
//           queue; a monitor pops and compares on the falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;
    localparam logic [3:0] ST_F = 4'd0, ST_D = 4'd1, ST_MA = 4'd2, ST_MR = 4'd3, ST_MWB = 4'd4,
                           ST_MW = 4'd5, ST_ER = 4'd6, ST_RWB = 4'd7, ST_EI = 4'd8, ST_IWB = 4'd9,
                           ST_BR = 4'd10, ST_J = 4'd11, ST_TRAP = 4'd15;
    localparam logic [2:0] A_NONE = 3'b000, A_ADD = 3'b101, A_AND = 3'b100, A_OR = 3'b110,
                           A_BEQ = 3'b001, A_BNE = 3'b111, A_RT = 3'b010;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       ext_zero, alu_src_a;
    logic [1:0] alu_src_b, pc_source, fault;
    logic [2:0] alu_op;
    logic [3:0] state;

    typedef struct {
        string       tag;
        logic [22:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .ext_zero(ext_zero), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
        .state(state), .fault(fault)
    );

    // {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, ext_zero, alu_src_a, alu_src_b, pc_source, alu_op, fault}
    logic [22:0] obs;
    assign obs = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, ext_zero, alu_src_a, alu_src_b, pc_source, alu_op, fault};

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Expected outputs for one cycle, taken from the controller's state table
    function automatic logic [22:0] exp_vec(input logic [3:0] st, input logic r,
                                            input logic [5:0] opc, input logic z,
                                            input logic rdy, input logic [2:0] aop,
                                            input logic [1:0] flt);
        logic e_pc, e_iord, e_mr, e_mw, e_ir, e_rd, e_m2r, e_rw, e_ez, e_sa;
        logic [1:0] e_sb, e_ps;
        e_pc  = r & (((st == ST_F) & rdy) | (st == ST_J) |
                     ((st == ST_BR) & (((opc == OP_BEQ) & z) | ((opc == OP_BNE) & ~z))));
        e_iord = (st == ST_MR) | (st == ST_MW);
        e_mr  = r & ((st == ST_F) | (st == ST_MR));
        e_mw  = r & (st == ST_MW);
        e_ir  = r & (st == ST_F) & rdy;
        e_rd  = (st == ST_RWB);
        e_m2r = (st == ST_MWB);
        e_rw  = r & ((st == ST_MWB) | (st == ST_RWB) | (st == ST_IWB));
        e_ez  = (st == ST_EI) & ((opc == OP_ANDI) | (opc == OP_ORI));
        e_sa  = (st == ST_MA) | (st == ST_ER) | (st == ST_EI) | (st == ST_BR);
        e_sb  = (st == ST_F) ? 2'b01 : (st == ST_D) ? 2'b11 :
                ((st == ST_MA) | (st == ST_EI)) ? 2'b10 : 2'b00;
        e_ps  = (st == ST_BR) ? 2'b01 : (st == ST_J) ? 2'b10 : 2'b00;
        return {st, e_pc, e_iord, e_mr, e_mw, e_ir, e_rd, e_m2r, e_rw, e_ez, e_sa,
                e_sb, e_ps, aop, flt};
    endfunction

    // Drive one cycle (called just after a rising edge) and queue its expectation
    task automatic cyc(input string tag, input logic r, input logic [5:0] opc, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [2:0] aop,
                       input logic [1:0] flt);
        sb_t e;
        rst_n = r; opcode = opc; zero = z; mem_ready = rdy;
        e.tag = tag;
        e.exp = exp_vec(st, r, opc, z, rdy, aop, flt);
        sb_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    end

    task automatic run_r(input string tag);
        cyc({tag, "_fetch"}, 1, OP_R, 0, 1, ST_F,   A_ADD,  2'b00);
        cyc({tag, "_dec"},   1, OP_R, 0, 1, ST_D,   A_RT,   2'b00);
        cyc({tag, "_exec"},  1, OP_R, 0, 1, ST_ER,  A_NONE, 2'b00);
        cyc({tag, "_wb"},    1, OP_R, 0, 1, ST_RWB, A_ADD,  2'b00);
    endtask

    task automatic run_br(input string tag, input logic [5:0] opc, input logic z);
        cyc({tag, "_fetch"},  1, opc, z, 1, ST_F,  A_ADD, 2'b00);
        cyc({tag, "_dec"},    1, opc, z, 1, ST_D,  (opc == OP_BNE) ? A_BNE : A_BEQ, 2'b00);
        cyc({tag, "_branch"}, 1, opc, z, 1, ST_BR, A_ADD, 2'b00);
    endtask

    task automatic run_i(input string tag, input logic [5:0] opc, input logic [2:0] aop);
        cyc({tag, "_fetch"}, 1, opc, 0, 1, ST_F,   A_ADD,  2'b00);
        cyc({tag, "_dec"},   1, opc, 0, 1, ST_D,   aop,    2'b00);
        cyc({tag, "_exec"},  1, opc, 0, 1, ST_EI,  A_NONE, 2'b00);
        cyc({tag, "_wb"},    1, opc, 0, 1, ST_IWB, A_ADD,  2'b00);
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_hold", 0, OP_R, 0, 1, ST_F, A_ADD, 2'b00);

        run_r("rtype");

        // lw with memory answering on the 4th MEM_READ cycle (edge of TIMEOUT=4)
        cyc("lw_fetch", 1, OP_LW, 0, 1, ST_F,  A_ADD,  2'b00);
        cyc("lw_dec",   1, OP_LW, 0, 1, ST_D,  A_ADD,  2'b00);
        cyc("lw_addr",  1, OP_LW, 0, 1, ST_MA, A_NONE, 2'b00);
        for (int i = 0; i < 3; i++)
            cyc("lw_wait", 1, OP_LW, 0, 0, ST_MR, A_NONE, 2'b00);
        cyc("lw_ready", 1, OP_LW, 0, 1, ST_MR,  A_NONE, 2'b00);
        cyc("lw_wb",    1, OP_LW, 0, 1, ST_MWB, A_ADD,  2'b00);

        run_br("beq_z1", OP_BEQ, 1);
        run_br("beq_z0", OP_BEQ, 0);
        run_br("bne_z0", OP_BNE, 0);
        run_br("bne_z1", OP_BNE, 1);

        run_i("andi", OP_ANDI, A_AND);
        run_i("ori",  OP_ORI,  A_OR);
        run_i("addi", OP_ADDI, A_ADD);

        cyc("sw_fetch", 1, OP_SW, 0, 1, ST_F,  A_ADD,  2'b00);
        cyc("sw_dec",   1, OP_SW, 0, 1, ST_D,  A_ADD,  2'b00);
        cyc("sw_addr",  1, OP_SW, 0, 1, ST_MA, A_NONE, 2'b00);
        cyc("sw_wait",  1, OP_SW, 0, 0, ST_MW, A_NONE, 2'b00);
        cyc("sw_ready", 1, OP_SW, 0, 1, ST_MW, A_ADD,  2'b00);

        cyc("j_fetch", 1, OP_J, 0, 1, ST_F, A_ADD,  2'b00);
        cyc("j_dec",   1, OP_J, 0, 1, ST_D, A_NONE, 2'b00);
        cyc("j_jump",  1, OP_J, 0, 1, ST_J, A_ADD,  2'b00);

        // Reset while waiting on memory aborts the load
        cyc("abort_fetch", 1, OP_LW, 0, 1, ST_F,  A_ADD,  2'b00);
        cyc("abort_dec",   1, OP_LW, 0, 1, ST_D,  A_ADD,  2'b00);
        cyc("abort_addr",  1, OP_LW, 0, 1, ST_MA, A_NONE, 2'b00);
        cyc("abort_wait",  1, OP_LW, 0, 0, ST_MR, A_NONE, 2'b00);
        cyc("abort_rst",   0, OP_LW, 0, 0, ST_MR, A_ADD,  2'b00);
        run_r("after_abort");

        // Fetch timeout: 4 waiting cycles then TRAP
        for (int i = 0; i < 3; i++)
            cyc("to_wait", 1, OP_R, 0, 0, ST_F, A_ADD, 2'b00);
        cyc("to_last",  1, OP_R, 0, 0, ST_F,    A_NONE, 2'b00);
        cyc("to_trap",  1, OP_R, 0, 0, ST_TRAP, A_NONE, 2'b10);
        cyc("to_trap2", 1, OP_R, 1, 1, ST_TRAP, A_NONE, 2'b10);
        cyc("to_rst",   0, OP_R, 0, 1, ST_TRAP, A_ADD,  2'b10);

        // Ready on the 4th cycle wins over the timeout
        for (int i = 0; i < 3; i++)
            cyc("late_wait", 1, OP_R, 0, 0, ST_F, A_ADD, 2'b00);
        cyc("late_ready", 1, OP_R, 0, 1, ST_F,   A_ADD,  2'b00);
        cyc("late_dec",   1, OP_R, 0, 1, ST_D,   A_RT,   2'b00);
        cyc("late_exec",  1, OP_R, 0, 1, ST_ER,  A_NONE, 2'b00);
        cyc("late_wb",    1, OP_R, 0, 1, ST_RWB, A_ADD,  2'b00);

        // Illegal opcode
        cyc("ill_fetch", 1, OP_BAD, 0, 1, ST_F, A_ADD,  2'b00);
        cyc("ill_dec",   1, OP_BAD, 0, 1, ST_D, A_NONE, 2'b00);
        for (int i = 0; i < 20; i++)
            cyc("ill_trap", 1, OP_BAD, 1'(i), 1, ST_TRAP, A_NONE, 2'b01);
        cyc("ill_rst", 0, OP_BAD, 0, 1, ST_TRAP, A_ADD, 2'b01);
        run_r("after_trap");

        chk("sb_drain", 23'(sb_q.size()), 23'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
